trig_capture_ctrl: RTL and testbench
====================================

TRIG_CAPTURE_CTRL -- requirements
Module: trig_capture_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port protTrig, input, 1, protocol trigger hit from the upstream protocol trigger stage.
REQ-004 SHALL have port chTrig, input, 5, per-channel trigger hits, CH1..CH5 in bits 0..4.
REQ-005 SHALL have port chTrig_en, input, 5, per-channel trigger enables.
REQ-006 SHALL have port prot_en, input, 1, protocol trigger enable.
REQ-007 SHALL have port arm, input, 1, single-cycle arm request.
REQ-008 SHALL have port abort, input, 1, single-cycle abort request.
REQ-009 SHALL have port smpl_en, input, 1, sample strobe from the capture clock divider.
REQ-010 SHALL have port trig_pos, input, 9, post-trigger sample count.
REQ-011 SHALL have port armed, output, 1, high in ARMED.
REQ-012 SHALL have port triggered, output, 1, high in TRIG and DONE.
REQ-013 SHALL have port capture_done, output, 1, high in DONE.
REQ-014 SHALL have port state, output, 2, encoding IDLE=0, ARMED=1, TRIG=2, DONE=3.
REQ-015 SHALL have port trig_time, output, 16, only when TRIG_TIMESTAMP_EN is defined.

Function
REQ-016 SHALL form cond = AND over i of (chTrig[i] | ~chTrig_en[i]), ANDed with (protTrig | ~prot_en), ANDed with (|chTrig_en | prot_en); cond is never true with no source enabled.
REQ-017 SHALL register all outputs; no output is a combinational function of inputs.
REQ-018 SHALL move IDLE->ARMED on the cycle after arm=1, and latch trig_pos into an internal 9-bit register at that edge.
REQ-019 SHALL move ARMED->TRIG on the cycle after cond=1 sampled in ARMED, clearing the post-trigger counter to 0.
REQ-020 SHALL, in TRIG, increment the post-trigger counter on each clk with smpl_en=1.
REQ-021 SHALL move TRIG->DONE on the edge where smpl_en=1 and counter+1 equals the latched trig_pos; capture_done rises the cycle after the trig_pos-th strobe.
REQ-022 SHALL, for latched trig_pos=0, move TRIG->DONE on the first edge after entering TRIG regardless of smpl_en.
REQ-023 SHALL, in DONE, hold state; arm=1 moves to ARMED, re-latches trig_pos, and clears triggered and capture_done.
REQ-024 SHALL ignore arm in ARMED and TRIG.
REQ-025 SHALL return to IDLE from any state on the edge after abort=1, clearing armed, triggered and capture_done; abort wins over simultaneous arm or cond.
REQ-026 SHALL ignore trig_pos changes after latching; cond is ignored outside ARMED.

Reset
REQ-027 SHALL, on rst=1, immediately force state=IDLE, armed=0, triggered=0, capture_done=0, post-trigger counter=0, latched trig_pos=0, and trig_time=0 when present, independent of clk; mid-capture reset discards the capture.

Configuration
REQ-028 SHALL, with TRIG_TIMESTAMP_EN defined, count smpl_en strobes in ARMED in a 16-bit counter: cleared on the arm edge, saturating at 0xFFFF, frozen on ARMED->TRIG, driven on trig_time and held until the next arm, abort or reset.
REQ-029 SHALL, without TRIG_TIMESTAMP_EN, omit the trig_time port and the timestamp counter; all other behaviour is identical.

Verification
REQ-030 Reset mid-TRIG: assert rst asynchronously -> state=0, triggered=0, capture_done=0 before the next clk edge.
REQ-031 chTrig_en=5'b00001, prot_en=1, trig_pos=4, arm; chTrig[0]=1 with protTrig=0 -> stays ARMED; then protTrig=1 -> triggered=1 next cycle; 4 smpl_en strobes -> capture_done=1 the cycle after the 4th.
REQ-032 trig_pos=0, arm, cond true -> TRIG for exactly one cycle, then capture_done=1 with no smpl_en.
REQ-033 All enables 0, chTrig=5'h1F, protTrig=1, arm -> remains ARMED indefinitely.
REQ-034 In TRIG with counter=2, abort and arm asserted on the same cycle -> IDLE next cycle, all flags 0; change trig_pos from 4 to 1 after a new arm -> capture still ends after 4 strobes.
REQ-035 TRIG_TIMESTAMP_EN: arm, 10 smpl_en strobes, then cond -> trig_time=10 and held through DONE; 70000 strobes before cond -> trig_time=0xFFFF.

Source files
------------

// File: rtl/trig_capture_ctrl.sv
// Trigger/capture sequencer: arms on request, waits for the combined trigger
// condition, then counts post-trigger samples. Optional timestamp: TRIG_TIMESTAMP_EN.
module trig_capture_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        protTrig,
    input  logic [4:0]  chTrig,
    input  logic [4:0]  chTrig_en,
    input  logic        prot_en,
    input  logic        arm,
    input  logic        abort,
    input  logic        smpl_en,
    input  logic [8:0]  trig_pos,
    output logic        armed,
    output logic        triggered,
    output logic        capture_done,
    output logic [1:0]  state
`ifdef TRIG_TIMESTAMP_EN
    ,
    output logic [15:0] trig_time
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_TRIG  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [8:0]  cnt_reg, cnt_next;
    logic [8:0]  tpos_reg, tpos_next;
    logic        armed_reg, triggered_reg, done_reg;
    logic [4:0]  ch_ok;
    logic        cond;
    logic        arm_edge;

    // A disabled channel never blocks the AND; at least one source must be enabled.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_ch
            assign ch_ok[gi] = chTrig[gi] | ~chTrig_en[gi];
        end
    endgenerate

    assign cond = (&ch_ok) & (protTrig | ~prot_en) & ((|chTrig_en) | prot_en);
    assign arm_edge = ~abort & arm & ((state_reg == S_IDLE) | (state_reg == S_DONE));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tpos_next  = tpos_reg;
        if (abort) begin
            state_next = S_IDLE;
            cnt_next   = 9'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (arm) begin
                        state_next = S_ARMED;
                        tpos_next  = trig_pos;
                    end
                end
                S_ARMED: begin
                    if (cond) begin
                        state_next = S_TRIG;
                        cnt_next   = 9'd0;
                    end
                end
                S_TRIG: begin
                    // A zero post-trigger count completes without waiting for a strobe.
                    if (tpos_reg == 9'd0) begin
                        state_next = S_DONE;
                    end else if (smpl_en) begin
                        cnt_next = cnt_reg + 9'd1;
                        if (cnt_reg + 9'd1 == tpos_reg) begin
                            state_next = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (arm) begin
                        state_next = S_ARMED;
                        tpos_next  = trig_pos;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= 9'd0;
            tpos_reg      <= 9'd0;
            armed_reg     <= 1'b0;
            triggered_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            tpos_reg      <= tpos_next;
            armed_reg     <= (state_next == S_ARMED);
            triggered_reg <= (state_next == S_TRIG) | (state_next == S_DONE);
            done_reg      <= (state_next == S_DONE);
        end
    end

    assign state        = state_reg;
    assign armed        = armed_reg;
    assign triggered    = triggered_reg;
    assign capture_done = done_reg;

`ifdef TRIG_TIMESTAMP_EN
    logic [15:0] ts_reg, ts_next;

    // Counts strobes while armed; freezes once the state leaves ARMED.
    always_comb begin
        ts_next = ts_reg;
        if (abort || arm_edge) begin
            ts_next = 16'd0;
        end else if (state_reg == S_ARMED && smpl_en && ts_reg != 16'hFFFF) begin
            ts_next = ts_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_reg <= 16'd0;
        end else begin
            ts_reg <= ts_next;
        end
    end

    assign trig_time = ts_reg;
`else
    logic unused_arm_edge;
    assign unused_arm_edge = arm_edge;
`endif

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Directed bench for trig_capture_ctrl with an expected-value queue.
// Timestamp checks run only when TRIG_TIMESTAMP_EN is defined.
module tb_trig_capture_ctrl;

    logic        clk;
    logic        rst;
    logic        protTrig;
    logic [4:0]  chTrig;
    logic [4:0]  chTrig_en;
    logic        prot_en;
    logic        arm;
    logic        abort;
    logic        smpl_en;
    logic [8:0]  trig_pos;
    logic        armed;
    logic        triggered;
    logic        capture_done;
    logic [1:0]  state;
`ifdef TRIG_TIMESTAMP_EN
    logic [15:0] trig_time;
`endif

    trig_capture_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .protTrig     (protTrig),
        .chTrig       (chTrig),
        .chTrig_en    (chTrig_en),
        .prot_en      (prot_en),
        .arm          (arm),
        .abort        (abort),
        .smpl_en      (smpl_en),
        .trig_pos     (trig_pos),
        .armed        (armed),
        .triggered    (triggered),
        .capture_done (capture_done),
        .state        (state)
`ifdef TRIG_TIMESTAMP_EN
        ,
        .trig_time    (trig_time)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, TRIG = 2'd2, DONE = 2'd3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {state, armed, triggered, capture_done} for a given state.
    function automatic logic [31:0] flags_of(logic [1:0] st);
        logic [4:0] f;
        f = {st, (st == ARMED), (st == TRIG || st == DONE), (st == DONE)};
        return {27'd0, f};
    endfunction

    task automatic push_state(string tag, logic [1:0] st);
        exp_t e;
        e.tag = tag;
        e.val = flags_of(st);
        sb_q.push_back(e);
    endtask

    task automatic check_flags();
        exp_t        e;
        logic [31:0] obs;
        e   = sb_q.pop_front();
        obs = {27'd0, state, armed, triggered, capture_done};
        n_tests++;
        assert (obs === e.val)
        else begin
            n_fail++;
            $error("FAIL %s: observed flags=%05b expected=%05b", e.tag, obs[4:0], e.val[4:0]);
        end
        $display("[TB] %s state=%0d armed=%0b trig=%0b done=%0b", e.tag, state, armed,
                 triggered, capture_done);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push expectation, apply one clock edge, compare.
    task automatic step(string tag, logic [1:0] st);
        push_state(tag, st);
        tick();
        check_flags();
    endtask

`ifdef TRIG_TIMESTAMP_EN
    task automatic check_ts(string tag, logic [15:0] exp_ts);
        exp_t e;
        e.tag = tag;
        e.val = {16'd0, exp_ts};
        sb_q.push_back(e);
        e = sb_q.pop_front();
        n_tests++;
        assert ({16'd0, trig_time} === e.val)
        else begin
            n_fail++;
            $error("FAIL %s: observed trig_time=%0d expected=%0d", e.tag, trig_time, e.val);
        end
        $display("[TB] %s trig_time=%0d", e.tag, trig_time);
    endtask
`endif

    initial begin
        rst = 1'b1; protTrig = 0; chTrig = 0; chTrig_en = 0; prot_en = 0;
        arm = 0; abort = 0; smpl_en = 0; trig_pos = 0;
        #12;
        push_state("reset", IDLE);
        check_flags();
        tick();
        rst = 1'b0;

        // Channel 0 AND protocol required; trig_pos=4.
        chTrig_en = 5'b00001; prot_en = 1; trig_pos = 9'd4; arm = 1;
        step("arm", ARMED);
        arm = 0; chTrig = 5'b00001; protTrig = 0;
        step("ch_only_1", ARMED);
        arm = 1;
        step("ch_only_arm_ignored", ARMED);
        arm = 0; protTrig = 1;
        step("cond_trig", TRIG);
        protTrig = 0; chTrig = 0; smpl_en = 1;
        step("strobe1", TRIG);
        arm = 1;
        step("strobe2_arm_ignored", TRIG);
        arm = 0; smpl_en = 0;
        step("gap", TRIG);
        smpl_en = 1;
        step("strobe3", TRIG);
        step("strobe4_done", DONE);
        smpl_en = 0;
        step("done_hold", DONE);

        // trig_pos=0: a single TRIG cycle then DONE without strobes.
        trig_pos = 9'd0; chTrig = 5'b00001; protTrig = 1; arm = 1;
        step("rearm_pos0", ARMED);
        arm = 0;
        step("pos0_trig", TRIG);
        step("pos0_done", DONE);

        // No enabled source: never triggers.
        abort = 1;
        step("abort_done", IDLE);
        abort = 0; chTrig_en = 0; prot_en = 0; chTrig = 5'h1F; protTrig = 1; arm = 1;
        step("noen_arm", ARMED);
        arm = 0;
        for (int i = 0; i < 6; i++) step("noen_hold", ARMED);

        // Abort beats arm mid-capture; latched trig_pos ignores later changes.
        abort = 1;
        step("abort_armed", IDLE);
        abort = 0; chTrig_en = 5'b00100; chTrig = 0; protTrig = 0; trig_pos = 9'd4; arm = 1;
        step("arm_b", ARMED);
        arm = 0; chTrig = 5'b00100;
        step("trig_b", TRIG);
        chTrig = 0; smpl_en = 1;
        step("b_strobe1", TRIG);
        step("b_strobe2", TRIG);
        smpl_en = 0; abort = 1; arm = 1; chTrig = 5'b00100;
        step("abort_vs_arm", IDLE);
        abort = 0; chTrig = 0; trig_pos = 9'd4;
        step("arm_c", ARMED);
        arm = 0; trig_pos = 9'd1; chTrig = 5'b00100;
        step("trig_c", TRIG);
        chTrig = 0; smpl_en = 1;
        step("c_strobe1", TRIG);
        step("c_strobe2", TRIG);
        step("c_strobe3", TRIG);
        step("c_strobe4_done", DONE);
        smpl_en = 0;

        // Asynchronous reset in the middle of TRIG.
        trig_pos = 9'd3; arm = 1;
        step("arm_d", ARMED);
        arm = 0; chTrig = 5'b00100;
        step("trig_d", TRIG);
        chTrig = 0;
        #2;
        rst = 1'b1;
        #1;
        push_state("async_rst", IDLE);
        check_flags();
        @(negedge clk);
        rst = 1'b0;
        tick();
        push_state("post_rst_idle", IDLE);
        check_flags();

`ifdef TRIG_TIMESTAMP_EN
        chTrig_en = 5'b00010; prot_en = 0; chTrig = 0; trig_pos = 9'd2; arm = 1;
        step("ts_arm", ARMED);
        check_ts("ts_cleared", 16'd0);
        arm = 0; smpl_en = 1;
        for (int i = 0; i < 10; i++) tick();
        smpl_en = 0; chTrig = 5'b00010;
        step("ts_trig", TRIG);
        check_ts("ts_10", 16'd10);
        chTrig = 0; smpl_en = 1;
        tick();
        step("ts_done", DONE);
        check_ts("ts_held_done", 16'd10);
        smpl_en = 0; arm = 1;
        step("ts_rearm", ARMED);
        check_ts("ts_rearm_clear", 16'd0);
        arm = 0; smpl_en = 1;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        #1;
        smpl_en = 0; chTrig = 5'b00010;
        step("ts_sat_trig", TRIG);
        check_ts("ts_saturated", 16'hFFFF);
        chTrig = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
